// File: rtl/alu_result_writeback.sv
// alu_result_writeback: EX-stage result consumer driving the register-file write port and overflow exceptions
module alu_result_writeback #(
  parameter logic [3:0] HI_REG = 4'd0,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_out,
  input  logic             of_detect,
  input  logic [2:0]       alu_func,
  input  logic [3:0]       rd,
  input  logic             wb_req,
  input  logic [15:0]      pc_in,
  output logic             wb_we,
  output logic [3:0]       wb_addr,
  output logic [15:0]      wb_data,
  output logic             exc_valid,
  output logic [15:0]      exc_pc,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] of_count
);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, EXC} state_t;
  state_t state_q, state_d;
  logic wide_q;
  logic [15:0] hi_q;
  logic acc, arith_of, exc_entry;
  logic wb_we_q, wb_we_d, exc_valid_q, exc_valid_d;
  logic [3:0] wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d, exc_pc_q, exc_pc_d;
  logic [CNT_W-1:0] of_count_q, of_count_d;
  assign in_ready  = state_q == IDLE || state_q == WR_HI || (state_q == WR_LO && !wide_q);
  assign acc       = in_valid && in_ready;
  assign arith_of  = alu_func[2:1] == 2'b00 && of_detect;
  assign exc_entry = state_d == EXC && state_q != EXC;
  // state register plus the parts of an accepted op needed after its accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wide_q  <= 1'b0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        wide_q <= alu_func[2:1] == 2'b10;
        hi_q   <= alu_out[31:16];
      end
    end
  end
  // next state: an accept always decides the new state, otherwise finish the current op
  always_comb begin
    state_d = acc ? (arith_of ? EXC : wb_req ? WR_LO : IDLE)
            : state_q == WR_LO ? (wide_q ? WR_HI : IDLE)
            : state_q == EXC && !exc_ack ? EXC : IDLE;
  end
  // output next values: WR_LO is only entered on an accept, so its address/data come straight from the inputs
  always_comb begin
    wb_we_d     = state_d == WR_LO || state_d == WR_HI;
    wb_addr_d   = state_d == WR_LO ? rd : state_d == WR_HI ? HI_REG : wb_addr_q;
    wb_data_d   = state_d == WR_LO ? alu_out[15:0] : state_d == WR_HI ? hi_q : wb_data_q;
    exc_valid_d = state_d == EXC;
    exc_pc_d    = exc_entry ? pc_in : exc_pc_q;
    of_count_d  = exc_entry && !(&of_count_q) ? of_count_q + 1'b1 : of_count_q;
  end
  // registered Moore outputs; reset clears them immediately, abandoning any pending HI write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
      of_count_q  <= '0;
    end else begin
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
      of_count_q  <= of_count_d;
    end
  end
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_pc    = exc_pc_q;
  assign of_count  = of_count_q;
endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Consumer end of the ALU result interface in the 5-stage pipelined datapath; sits between EX and the register-file write port.
- Accepts one ALU result per handshake: 32-bit out, overflow flag, function code, destination register, PC.
- Writes 16-bit results to the register file in one cycle; writes 32-bit multiply/divide results over two cycles (lo to rd, hi to HI_REG).
- Converts add/sub overflow into a held exception toward the control unit and suppresses that writeback.

Parameters:
- HI_REG, 0, register-file address receiving the upper 16 bits of multiply/divide results.
- CNT_W, 8, width of the saturating overflow-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  block can accept a result this cycle.
- alu_out  in  32  ALU result.
- of_detect  in  1  ALU overflow flag.
- alu_func  in  3  ALU function code of the result.
- rd  in  4  destination register.
- wb_req  in  1  instruction writes a register.
- pc_in  in  16  PC of the instruction.
- wb_we  out  1  register-file write enable.
- wb_addr  out  4  register-file write address.
- wb_data  out  16  register-file write data.
- exc_valid  out  1  overflow exception pending.
- exc_pc  out  16  PC of the overflowing instruction.
- exc_ack  in  1  control unit has taken the exception.
- of_count  out  CNT_W  saturating count of overflow exceptions.

Behaviour:
- Function classes:
  - 000 add and 001 sub are arithmetic and overflow-checked.
  - 100 mult and 101 div are wide: 32-bit result, of_detect ignored.
  - All other codes are narrow: low 16 bits used, of_detect ignored.
- Accept rule: the block captures alu_out, of_detect, alu_func, rd, wb_req and pc_in on a rising edge where in_valid && in_ready. Inputs are not sampled at any other time.
- States:
  - IDLE, WR_LO, WR_HI and EXC.
  - in_ready = IDLE, or WR_LO with a non-wide op, or WR_HI. It is 0 in EXC and 0 in WR_LO with a wide op.
- Next state on accept, from any ready state:
  - arithmetic op with of_detect=1 goes to EXC, regardless of wb_req.
  - otherwise wb_req=1 goes to WR_LO.
  - otherwise (wb_req=0) goes to IDLE; the op is dropped with no write.
- Without an accept:
  - WR_LO with a wide op goes to WR_HI.
  - WR_LO with a narrow op goes to IDLE.
  - WR_HI goes to IDLE.
  - EXC stays in EXC until exc_ack, then goes to IDLE.
- Outputs are Moore (registered state):
  - WR_LO: wb_we=1, wb_addr=rd, wb_data=alu_out[15:0].
  - WR_HI: wb_we=1, wb_addr=HI_REG, wb_data=alu_out[31:16].
  - EXC: exc_valid=1, exc_pc=captured pc.
  - All other states: wb_we=0. wb_addr and wb_data hold their last values.
- Latency: the first write occurs the cycle after accept. Back-to-back narrow ops sustain one write per cycle.
- Wide-op timing: a wide op takes 2 write cycles. The next op may be accepted in the WR_HI cycle, and its WR_LO follows immediately.
- of_count increments by 1 on each entry to EXC and saturates at all-ones (no wrap).
- exc_ack outside EXC is ignored.
- Reset (asserted at any time, including mid WR_HI or in EXC):
  - state goes to IDLE immediately and all outputs clear: wb_we=0, wb_addr=0, wb_data=0, exc_valid=0, exc_pc=0, of_count=0.
  - in_ready=1 once reset is released.
  - A partially written wide result is abandoned and no HI write is issued.

Test Plan:
- Narrow add: alu_func=000, alu_out=0x0000149C (5076+200), of_detect=0, rd=3, wb_req=1 -> next cycle wb_we=1, wb_addr=3, wb_data=0x149C; wb_we=0 the cycle after.
- Wide mult: alu_func=100, alu_out=0x000F7DA0 (5076*200), rd=5 -> cycle 1 writes 0x7DA0 to addr 5 with in_ready=0; cycle 2 writes 0x000F to addr 0 with in_ready=1.
- Overflow: alu_func=000, alu_out=0x00019998 (0xCCCC+0xCCCC), of_detect=1, pc_in=0x0040 -> no write, exc_valid=1, exc_pc=0x0040, in_ready=0.
  - Hold exc_ack=0 for 3 cycles -> exc_valid stays 1.
  - Pulse exc_ack -> IDLE; of_count=1.
- Back-to-back: narrow ops to rd=1,2,3 on consecutive cycles with in_valid=1 -> three consecutive writes with no bubble. A mult accepted in the WR_HI cycle of an earlier mult starts its WR_LO on the next cycle.
- Ignored/dropped ops: sub with of_detect=0 and wb_req=0 -> no write, no exception. Mult with of_detect=1 -> normal two writes, of_count unchanged.
- Reset: assert rst_n=0 asynchronously in a WR_HI cycle -> wb_we drops immediately, all outputs zero. After release, in_ready=1 and no HI write is issued.
- Saturation: CNT_W=2, force 5 overflow exceptions -> of_count reads 3.
